// File: rtl/change_dispense_ctrl.sv
// Change dispenser: pays an amount back as A/B/C coins, largest first,
// through a req/ack handshake to the coin ejector.
module change_dispense_ctrl #(
  parameter int DEN_A       = 100,
  parameter int DEN_B       = 50,
  parameter int DEN_C       = 20,
  parameter int ACK_TIMEOUT = 3,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] amount,
  input  logic       tick_1hz,
  input  logic [2:0] hopper_empty,
  input  logic       coin_ack,
  output logic       eject_req,
  output logic [1:0] eject_sel,
  output logic [9:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [9:0] DA = 10'(DEN_A);
  localparam logic [9:0] DB = 10'(DEN_B);
  localparam logic [9:0] DC = 10'(DEN_C);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, EJECT, GAP, DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;

  logic can_a, can_b, can_c;
  logic pick_a, pick_b, pick_c, pick_none;
  logic [9:0] den;

  assign can_a = !hopper_empty[2] && (remaining >= DA);
  assign can_b = !hopper_empty[1] && (remaining >= DB);
  assign can_c = !hopper_empty[0] && (remaining >= DC);

  // one-hot priority so the decoder below stays unique
  assign pick_a    = can_a;
  assign pick_b    = can_b && !can_a;
  assign pick_c    = can_c && !can_a && !can_b;
  assign pick_none = !(can_a || can_b || can_c);

  always_comb begin
    den = DC;
    unique case (eject_sel)
      2'd2:    den = DA;
      2'd1:    den = DB;
      default: den = DC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      gap_cnt   <= '0;
      eject_req <= 1'b0;
      eject_sel <= 2'd0;
      remaining <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= amount;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          tick_cnt <= '0;
          unique case (1'b1)
            pick_a: begin
              eject_sel <= 2'd2;
              eject_req <= 1'b1;
              state     <= EJECT;
            end
            pick_b: begin
              eject_sel <= 2'd1;
              eject_req <= 1'b1;
              state     <= EJECT;
            end
            pick_c: begin
              eject_sel <= 2'd0;
              eject_req <= 1'b1;
              state     <= EJECT;
            end
            pick_none: begin
              err   <= (remaining != 10'd0);
              done  <= 1'b1;
              state <= DONE;
            end
            default: state <= DONE;
          endcase
        end
        EJECT: begin
          if (coin_ack) begin
            remaining <= remaining - den;
            eject_req <= 1'b0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (tick_1hz) begin
            if (tick_cnt == T_LAST) begin
              eject_req <= 1'b0;
              err       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == G_LAST) begin
            state <= SELECT;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: coin sequences,
// residue error, empty hopper, ack timeout, async reset, zero amount.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] amount = '0;
  logic       tick_1hz = 1'b0;
  logic [2:0] hopper_empty = '0;
  logic       coin_ack = 1'b0;
  logic       eject_req;
  logic [1:0] eject_sel;
  logic [9:0] remaining;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  change_dispense_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .amount       (amount),
    .tick_1hz     (tick_1hz),
    .hopper_empty (hopper_empty),
    .coin_ack     (coin_ack),
    .eject_req    (eject_req),
    .eject_sel    (eject_sel),
    .remaining    (remaining),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns #1 after the edge that accepted start
  task automatic start_job(input logic [9:0] a);
    step();
    start  = 1'b1;
    amount = a;
    step();
    start  = 1'b0;
    amount = '0;
  endtask

  task automatic serve_coin(output logic [1:0] sel,
                            output bit ok);
    ok  = 1'b0;
    sel = 2'd3;
    for (int i = 0; i < 40; i++) begin
      if (eject_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      sel = eject_sel;
      step();
      step();
      coin_ack = 1'b1;
      step();
      coin_ack = 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({eject_req, eject_sel, remaining, busy, done, err}
        !== 16'd0) begin
      n_bad++;
      $display("FAIL reset: outs=%h required 0",
               {eject_req, eject_sel, remaining, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_b_then_c();
    logic [1:0] sel;
    bit ok;
    start_job(10'd70);
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 10'd70) begin
      n_bad++;
      $display("FAIL t1_accept: busy=%b rem=%0d required 1/70",
               busy, remaining);
    end
    start  = 1'b1;
    amount = 10'd999;
    step();
    start  = 1'b0;
    amount = '0;
    serve_coin(sel, ok);
    n_cmp++;
    if (!ok || sel !== 2'd1 || remaining !== 10'd20) begin
      n_bad++;
      $display("FAIL t1_coin1: ok=%b sel=%0d rem=%0d required 1/1/20",
               ok, sel, remaining);
    end
    serve_coin(sel, ok);
    n_cmp++;
    if (!ok || sel !== 2'd0 || remaining !== 10'd0) begin
      n_bad++;
      $display("FAIL t1_coin2: ok=%b sel=%0d rem=%0d required 1/0/0",
               ok, sel, remaining);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || err !== 1'b0 || remaining !== 10'd0) begin
      n_bad++;
      $display("FAIL t1_done: ok=%b err=%b rem=%0d required 1/0/0",
               ok, err, remaining);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || eject_req !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_idle: done=%b busy=%b req=%b required 0/0/0",
               done, busy, eject_req);
    end
  endtask

  task automatic test_residue();
    logic [1:0] sel;
    bit ok;
    start_job(10'd130);
    step();
    serve_coin(sel, ok);
    n_cmp++;
    if (!ok || sel !== 2'd2 || remaining !== 10'd30) begin
      n_bad++;
      $display("FAIL t2_coin1: ok=%b sel=%0d rem=%0d required 1/2/30",
               ok, sel, remaining);
    end
    serve_coin(sel, ok);
    n_cmp++;
    if (!ok || sel !== 2'd0 || remaining !== 10'd10) begin
      n_bad++;
      $display("FAIL t2_coin2: ok=%b sel=%0d rem=%0d required 1/0/10",
               ok, sel, remaining);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || err !== 1'b1 || remaining !== 10'd10) begin
      n_bad++;
      $display("FAIL t2_done: ok=%b err=%b rem=%0d required 1/1/10",
               ok, err, remaining);
    end
    step();
  endtask

  task automatic test_empty_hopper();
    logic [1:0] sel;
    bit ok;
    logic [9:0] exp_rem;
    hopper_empty = 3'b100;
    exp_rem = 10'd200;
    start_job(10'd200);
    step();
    for (int k = 0; k < 4; k++) begin
      serve_coin(sel, ok);
      exp_rem = exp_rem - 10'd50;
      n_cmp++;
      if (!ok || sel !== 2'd1 || remaining !== exp_rem) begin
        n_bad++;
        $display("FAIL t3_coin%0d: ok=%b sel=%0d rem=%0d required 1/1/%0d",
                 k, ok, sel, remaining, exp_rem);
      end
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || err !== 1'b0 || remaining !== 10'd0) begin
      n_bad++;
      $display("FAIL t3_done: ok=%b err=%b rem=%0d required 1/0/0",
               ok, err, remaining);
    end
    hopper_empty = 3'b000;
    step();
  endtask

  task automatic test_timeout();
    start_job(10'd50);
    step();
    n_cmp++;
    if (eject_req !== 1'b1 || eject_sel !== 2'd1) begin
      n_bad++;
      $display("FAIL t4_req: req=%b sel=%0d required 1/1",
               eject_req, eject_sel);
    end
    hopper_empty = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      step();
      step();
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      if (k < 3) begin
        n_cmp++;
        if (eject_req !== 1'b1 || eject_sel !== 2'd1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL t4_hold%0d: req=%b sel=%0d done=%b required 1/1/0",
                   k, eject_req, eject_sel, done);
        end
      end
    end
    n_cmp++;
    if (eject_req !== 1'b0 || err !== 1'b1 || remaining !== 10'd50
        || done !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_timeout: req=%b err=%b rem=%0d done=%b required 0/1/50/1",
               eject_req, err, remaining, done);
    end
    hopper_empty = 3'b000;
    step();
  endtask

  task automatic test_async_reset();
    start_job(10'd50);
    step();
    n_cmp++;
    if (eject_req !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_req: req=%b required 1", eject_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (eject_req !== 1'b0 || busy !== 1'b0 || remaining !== 10'd0
        || err !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_reset: req=%b busy=%b rem=%0d err=%b required 0/0/0/0",
               eject_req, busy, remaining, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if (eject_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_idle: req=%b busy=%b done=%b required 0/0/0",
               eject_req, busy, done);
    end
  endtask

  task automatic test_zero_amount();
    start_job(10'd0);
    n_cmp++;
    if (done !== 1'b0 || eject_req !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_select: done=%b req=%b busy=%b required 0/0/1",
               done, eject_req, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || eject_req !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_done: done=%b req=%b err=%b required 1/0/0",
               done, eject_req, err);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t6_after: done=%b busy=%b required 0/0",
               done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_b_then_c();
    test_residue();
    test_empty_hopper();
    test_timeout();
    test_async_reset();
    test_zero_amount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
